// File: rtl/wb_arbiter_pkg.sv
// Shared constants and types for the write-back path.
// Defines DATA_SIZE, REGFILE_SIZE and REGFILE_LOGSIZE.
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif
`ifndef REGFILE_SIZE
`define REGFILE_SIZE 32
`endif
`ifndef REGFILE_LOGSIZE
`define REGFILE_LOGSIZE 5
`endif

package wb_arbiter_pkg;
  localparam int unsigned DATA_W  = `DATA_SIZE;
  localparam int unsigned REG_N   = `REGFILE_SIZE;
  localparam int unsigned REG_LOG = `REGFILE_LOGSIZE;

  typedef enum logic {
    WB_ALU = 1'b0,
    WB_LSU = 1'b1
  } wb_src_t;
endpackage

// File: rtl/wb_arbiter_rr_arb2.sv
// Two-request round-robin arbiter with one-hot grants (bit 0 ALU, bit 1 LSU).
// Grants are forced low while nrst is asserted.
module rr_arb2
  import wb_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       nrst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  wb_src_t ptr;

  always_comb begin
    gnt = '0;
    if (nrst) begin
      if (req[0] && req[1]) begin
        if (ptr == WB_ALU) gnt[0] = 1'b1;
        else               gnt[1] = 1'b1;
      end else begin
        gnt = req;
      end
    end
  end

  // Pointer always moves to the source that was not just served.
  always_ff @(posedge clk) begin
    if (!nrst)       ptr <= WB_ALU;
    else if (gnt[0]) ptr <= WB_LSU;
    else if (gnt[1]) ptr <= WB_ALU;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges ALU and LSU results into one register-file write
// port and tracks pending writes. Define WB_FWD_EN to mask hazards bypassed by the register file.
module wb_arbiter
  import wb_arbiter_pkg::*;
(
  input  logic                        clk,
  input  logic                        nrst,
  input  logic                        alu_valid,
  output logic                        alu_ready,
  input  logic [`REGFILE_LOGSIZE-1:0] alu_rd,
  input  logic [`DATA_SIZE-1:0]       alu_data,
  input  logic                        lsu_valid,
  output logic                        lsu_ready,
  input  logic [`REGFILE_LOGSIZE-1:0] lsu_rd,
  input  logic [`DATA_SIZE-1:0]       lsu_data,
  input  logic                        alloc_en,
  input  logic [`REGFILE_LOGSIZE-1:0] alloc_addr,
  input  logic [`REGFILE_LOGSIZE-1:0] rs1_addr,
  input  logic [`REGFILE_LOGSIZE-1:0] rs2_addr,
  output logic                        hazard,
  output logic [`REGFILE_SIZE-1:0]    busy,
  output logic                        wr_en,
  output logic [`REGFILE_LOGSIZE-1:0] wr_addr,
  output logic [`DATA_SIZE-1:0]       wr_data
);

  logic [1:0]                  gnt;
  logic                        xfer_any;
  logic                        do_write;
  logic [`REGFILE_LOGSIZE-1:0] sel_rd;
  logic [`DATA_SIZE-1:0]       sel_data;
  logic                        pend1;
  logic                        pend2;

  rr_arb2 u_arb (
    .clk  (clk),
    .nrst (nrst),
    .req  ({lsu_valid, alu_valid}),
    .gnt  (gnt)
  );

  assign alu_ready = gnt[0];
  assign lsu_ready = gnt[1];

  always_comb begin
    xfer_any = gnt[0] | gnt[1];
    sel_rd   = gnt[1] ? lsu_rd   : alu_rd;
    sel_data = gnt[1] ? lsu_data : alu_data;
    do_write = xfer_any && (sel_rd != '0);
  end

  // A transfer to x0 is consumed but leaves the write port idle and holding.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= do_write;
      if (do_write) begin
        wr_addr <= sel_rd;
        wr_data <= sel_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      busy <= '0;
    end else begin
      busy[0] <= 1'b0;
      for (int unsigned i = 1; i < REG_N; i++) begin
        if (alloc_en && alloc_addr == REG_LOG'(i))
          busy[i] <= 1'b1;
        else if (wr_en && wr_addr == REG_LOG'(i))
          busy[i] <= 1'b0;
      end
    end
  end

  always_comb begin
    pend1 = busy[rs1_addr] && (rs1_addr != '0);
    pend2 = busy[rs2_addr] && (rs2_addr != '0);
`ifdef WB_FWD_EN
    if (wr_en && wr_addr == rs1_addr) pend1 = 1'b0;
    if (wr_en && wr_addr == rs2_addr) pend2 = 1'b0;
`endif
    hazard = pend1 | pend2;
  end

endmodule
